// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer: state encoding,
// LFSR feedback taps and the BCD all-nines helper.
package reaction_timer_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 16;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ARMED = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  function automatic logic [BCD_W*MAX_DIGITS-1:0] all_nines(input int unsigned n);
    logic [BCD_W*MAX_DIGITS-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) v[i*BCD_W +: BCD_W] = 4'd9;
    end
    return v;
  endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Button inputs and display/status outputs of the reaction timer core.
interface reaction_timer_if #(parameter int NUM_DIGITS = 4);
  import reaction_timer_pkg::*;

  logic                          start;
  logic                          react;
  logic                          stim_led;
  logic [BCD_W*NUM_DIGITS-1:0]   time_bcd;
  logic [BCD_W*NUM_DIGITS-1:0]   best_bcd;
  logic                          best_valid;
  logic                          result_valid;
  logic                          false_start;
  logic                          overflow;
  logic [2:0]                    state;

  modport master (
    output start, react,
    input  stim_led, time_bcd, best_bcd, best_valid, result_valid,
           false_start, overflow, state
  );

  modport slave (
    input  start, react,
    output stim_led, time_bcd, best_bcd, best_valid, result_valid,
           false_start, overflow, state
  );
endinterface

// File: rtl/reaction_timer_bcd_counter.sv
// Multi-digit BCD up-counter with ripple decimal carry; clear beats increment.
// max flags the all-nines value so the owner can saturate instead of wrapping.
module bcd_counter
  import reaction_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        inc,
  output logic [BCD_W*NUM_DIGITS-1:0] bcd,
  output logic                        max
);

  localparam int W = BCD_W * NUM_DIGITS;
  localparam logic [BCD_W*MAX_DIGITS-1:0] NINES_FULL = all_nines(NUM_DIGITS);

  logic [W-1:0] bcd_d;
  logic         carry;

  always_comb begin
    bcd_d = bcd;
    carry = inc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (bcd[i*BCD_W +: BCD_W] == 4'd9) begin
          bcd_d[i*BCD_W +: BCD_W] = '0;
        end else begin
          bcd_d[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) bcd <= '0;
    else     bcd <= bcd_d;
  end

  assign max = (bcd == NINES_FULL[W-1:0]);

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction timer: random stimulus delay, BCD reaction count, false-start and
// overflow detection, best-time tracking. Button edges act two cycles after the input rises.
module reaction_timer_core
  import reaction_timer_pkg::*;
#(
  parameter int          CLK_HZ     = 100_000_000,
  parameter int          TICK_HZ    = 1000,
  parameter int          NUM_DIGITS = 4,
  parameter int          MIN_DELAY  = 1000,
  parameter int          DELAY_SPAN = 2048,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             ck_rst,
  reaction_timer_if.slave  io
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam int DLY_W = $clog2(MIN_DELAY + DELAY_SPAN + 1);
  localparam int W     = BCD_W * NUM_DIGITS;
  localparam logic [BCD_W*MAX_DIGITS-1:0] NINES_FULL = all_nines(NUM_DIGITS);

  state_t             state_q, state_d;
  logic               start_prev, react_prev, start_edge, react_edge;
  logic [15:0]        lfsr;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [DLY_W-1:0]   dly_cnt, dly_load;
  logic [W-1:0]       cnt_bcd, best;
  logic               cnt_max, cnt_inc;
  logic               best_valid, result_valid, false_start, overflow;
  logic               load, arm, hit, sat, fault;

  assign tick     = (div_cnt == DIV_W'(DIV - 1));
  assign dly_load = DLY_W'(MIN_DELAY) + DLY_W'(lfsr & 16'(DELAY_SPAN - 1));
  // A react edge freezes the count even if a tick lands in the same cycle.
  assign cnt_inc  = (state_q == ST_ARMED) && tick && !react_edge && !cnt_max;

  always_ff @(posedge clk) begin
    if (ck_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    arm     = 1'b0;
    hit     = 1'b0;
    sat     = 1'b0;
    fault   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start_edge) begin
          state_d = ST_WAIT;
          load    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (react_edge) begin
          state_d = ST_FAULT;
          fault   = 1'b1;
        end else if (tick && dly_cnt == '0) begin
          state_d = ST_ARMED;
          arm     = 1'b1;
        end
      end
      ST_ARMED: begin
        if (react_edge) begin
          state_d = ST_DONE;
          hit     = 1'b1;
        end else if (tick && cnt_max) begin
          state_d = ST_DONE;
          sat     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ck_rst) begin
      start_prev   <= 1'b0;
      react_prev   <= 1'b0;
      start_edge   <= 1'b0;
      react_edge   <= 1'b0;
      lfsr         <= LFSR_SEED;
      div_cnt      <= '0;
      dly_cnt      <= '0;
      best         <= NINES_FULL[W-1:0];
      best_valid   <= 1'b0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      start_prev   <= io.start;
      react_prev   <= io.react;
      start_edge   <= io.start & ~start_prev;
      react_edge   <= io.react & ~react_prev;
      lfsr         <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      div_cnt      <= (load || arm || tick) ? '0 : div_cnt + 1'b1;
      result_valid <= hit;

      if (load)
        dly_cnt <= dly_load;
      else if (state_q == ST_WAIT && tick && dly_cnt != '0)
        dly_cnt <= dly_cnt - 1'b1;

      if (load) begin
        false_start <= 1'b0;
        overflow    <= 1'b0;
      end
      if (fault) false_start <= 1'b1;
      if (sat)   overflow    <= 1'b1;

      // BCD ordering matches binary ordering, so a plain compare suffices.
      if (hit && (!best_valid || cnt_bcd < best)) begin
        best       <= cnt_bcd;
        best_valid <= 1'b1;
      end
    end
  end

  bcd_counter #(.NUM_DIGITS(NUM_DIGITS)) u_count (
    .clk (clk),
    .clr (ck_rst | load),
    .inc (cnt_inc),
    .bcd (cnt_bcd),
    .max (cnt_max)
  );

  assign io.stim_led     = (state_q == ST_ARMED);
  assign io.time_bcd     = cnt_bcd;
  assign io.best_bcd     = best;
  assign io.best_valid   = best_valid;
  assign io.result_valid = result_valid;
  assign io.false_start  = false_start;
  assign io.overflow     = overflow;
  assign io.state        = state_q;

endmodule

// File: doc/reaction_timer_core.md
# reaction_timer_core

Parametrised reaction-timer engine: on `start` it waits a pseudo-random delay, lights the stimulus LED, then counts elapsed time in BCD until `react` is pressed. It detects false starts and saturating overflow, and keeps the best (lowest) valid time since reset. It sits between the debounced button inputs and the seven-segment display driver, feeding the driver a packed BCD digit bus directly.

## Interface

- `CLK_HZ`, 100_000_000, input clock frequency.
- `TICK_HZ`, 1000, count resolution (1 ms). `DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `NUM_DIGITS`, 4, BCD digits for current and best time.
- `MIN_DELAY`, 1000, minimum stimulus delay in ticks.
- `DELAY_SPAN`, 2048, random delay span in ticks; must be a power of 2 and ≤ 65536.
- `LFSR_SEED`, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- `clk`, in, 1: the single clock.
- `ck_rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: level, already synchronised and debounced upstream. The block acts on its rising edge.
- `react`, in, 1: level, already synchronised and debounced upstream. The block acts on its rising edge.
- `stim_led`, out, 1: high while the timer is armed (counting).
- `time_bcd`, out, 4*NUM_DIGITS: current or last time. Digit 0 is the LSB nibble.
- `best_bcd`, out, 4*NUM_DIGITS: best valid time.
- `best_valid`, out, 1: high once at least one valid result exists.
- `result_valid`, out, 1: one-cycle pulse when a valid result is captured.
- `false_start`, out, 1: held high in FAULT.
- `overflow`, out, 1: held high after a saturated trial.
- `state`, out, 3: encoded FSM state, for debug and LEDs.

## Operation

- Edge detect: registered previous value of `start` and `react`. Edge = `in & ~prev`. `prev` resets to 0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It advances every cycle, including in IDLE.
- Tick divider: counts 0..DIV-1 and pulses `tick` for one cycle at DIV-1. It is cleared to 0 on every transition into WAIT or ARMED.
- FSM states:
  - IDLE = 0
  - WAIT = 1
  - ARMED = 2
  - DONE = 3
  - FAULT = 4
- IDLE/DONE/FAULT + start edge → WAIT:
  - Delay counter loads `MIN_DELAY + (lfsr & (DELAY_SPAN-1))`.
  - `time_bcd` clears to 0.
  - `false_start` and `overflow` clear.
- WAIT:
  - Each tick decrements the delay counter.
  - When the counter is 0 and a tick arrives → ARMED.
  - React edge → FAULT. This takes priority over the tick in the same cycle.
  - Start edges are ignored.
- ARMED:
  - `stim_led` = 1.
  - Each tick increments the BCD counter, with a ripple decimal carry.
  - React edge → DONE. The count freezes; a simultaneous tick is discarded.
  - `result_valid` pulses.
  - If `time < best` or `!best_valid`, then best ← time and `best_valid` ← 1.
  - Tick while the count is all-9s → DONE with `overflow` = 1. There is no `result_valid` and best is not updated.
  - Start edges are ignored.
- DONE/FAULT: hold outputs until a start edge.
- Best comparison is on the BCD value, digit-wise from the MSB. It is equivalent to a binary compare.

## Timing

- Reset values:
  - state IDLE, `stim_led` 0, `time_bcd` 0.
  - `best_bcd` all 9s, `best_valid` 0.
  - `result_valid` 0, `false_start` 0, `overflow` 0.
  - LFSR = `LFSR_SEED`, divider 0.
- Reset mid-trial: next cycle is IDLE with the above values. Best is lost.
- Input edge to state change: `start`/`react` high in cycle N → edge seen in cycle N+1 → state/outputs updated at the end of N+1 (visible in N+2).
- `result_valid`, `best_bcd`, and DONE are all visible in the same cycle.
- Stimulus delay, measured from WAIT entry to `stim_led` rise: (loaded+1)×DIV cycles ±1.
- Reported time error: ≤ 1 tick low, due to the truncating count.

## Structure

- Shared package `reaction_timer_pkg`:
  - state enum/localparams.
  - LFSR tap constant.
  - BCD digit width (4).
  - function for the all-9s constant of N digits.
- Sub-module `bcd_counter`:
  - parameter `NUM_DIGITS`.
  - inputs `clr`, `inc`; outputs `bcd`, `max` (all 9s).
  - synchronous clear has priority over `inc`.
- Tick divider and LFSR stay inline.

## Test plan

Bench parameters: `CLK_HZ`=1000, `TICK_HZ`=100 (DIV=10), `NUM_DIGITS`=2, `MIN_DELAY`=3, `DELAY_SPAN`=4.

- Reset, then idle 50 cycles → state 0, `time_bcd` 8'h00, `best_bcd` 8'h99, `best_valid` 0, `stim_led` 0.
- Start edge, force the LFSR low bits to 2 → `stim_led` rises (3+2+1)×10=60 ±1 cycles after WAIT entry. React 125 cycles later → `time_bcd` 8'h12, `result_valid` 1 cycle, `best_bcd` 8'h12.
- Second trial with react at 9 ticks → best becomes 8'h09. Third trial at 15 ticks → best stays 8'h09, and `result_valid` still pulses.
- React during WAIT → state 4, `false_start` 1, `stim_led` never rises, best unchanged. A following start clears `false_start`.
- No react in ARMED → count reaches 8'h99, next tick → DONE, `overflow` 1, no `result_valid`, best unchanged.
- Assert `ck_rst` for 1 cycle mid-ARMED → IDLE next cycle, `best_valid` 0, `stim_led` 0.
- React edge coincident with a tick → count not incremented.
